// File: rtl/alu_result_fifo_if.sv
// Bus bundle between the ALU-facing producer, the result FIFO and its consumer.
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1; valid never depends on ready combinationally.
interface alu_result_fifo_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_r;
    logic             in_z;
    logic             in_c;
    logic             in_s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic             out_z;
    logic             out_c;
    logic             out_s;
    logic [AW:0]      count;
    logic             sticky_c;
    logic             sticky_s;
    logic             drop_err;
    logic             sticky_clr;

    // Producer/consumer/software side
    modport master (
        output in_valid, in_r, in_z, in_c, in_s, out_ready, sticky_clr,
        input  in_ready, out_valid, out_r, out_z, out_c, out_s,
               count, sticky_c, sticky_s, drop_err
    );

    // FIFO side
    modport slave (
        input  in_valid, in_r, in_z, in_c, in_s, out_ready, sticky_clr,
        output in_ready, out_valid, out_r, out_z, out_c, out_s,
               count, sticky_c, sticky_s, drop_err
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results {s,c,z,r}, with sticky carry/sign/overrun status.
// Full/empty come from the occupancy counter only, so pointers may wrap freely.
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_fifo_if.slave  bus
);
    localparam int          EW       = WIDTH + 3;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          sticky_c_q, sticky_c_d;
    logic          sticky_s_q, sticky_s_d;
    logic          drop_err_q, drop_err_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push     = bus.in_valid && !full;
    assign pop      = bus.out_ready && !empty;
    assign wr_entry = {bus.in_s, bus.in_c, bus.in_z, bus.in_r};
    assign head     = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and sticky status
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sticky_c_d = sticky_c_q;
        sticky_s_d = sticky_s_q;
        drop_err_d = drop_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end

        // Clear first, then OR in new events so a same-cycle set survives
        if (bus.sticky_clr) begin
            sticky_c_d = 1'b0;
            sticky_s_d = 1'b0;
            drop_err_d = 1'b0;
        end
        if (push && bus.in_c) begin
            sticky_c_d = 1'b1;
        end
        if (push && bus.in_s) begin
            sticky_s_d = 1'b1;
        end
        if (bus.in_valid && full) begin
            drop_err_d = 1'b1;
        end
    end

    // Control/status registers; reset discards all stored entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_c_q <= 1'b0;
            sticky_s_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_c_q <= sticky_c_d;
            sticky_s_q <= sticky_s_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Outputs: head entry is visible only while non-empty, otherwise zeros
    always_comb begin
        bus.in_ready  = !full;
        bus.out_valid = !empty;
        bus.count     = count_q;
        bus.sticky_c  = sticky_c_q;
        bus.sticky_s  = sticky_s_q;
        bus.drop_err  = drop_err_q;
        bus.out_r     = '0;
        bus.out_z     = 1'b0;
        bus.out_c     = 1'b0;
        bus.out_s     = 1'b0;
        if (!empty) begin
            bus.out_r = head[WIDTH-1:0];
            bus.out_z = head[WIDTH];
            bus.out_c = head[WIDTH+1];
            bus.out_s = head[WIDTH+2];
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: drives at the falling edge, checks at the next one.
module tb_alu_result_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [6:0] exp_q[$];
    logic [6:0] exp_e;

    alu_result_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] head_entry();
        return {25'd0, bus.out_s, bus.out_c, bus.out_z, bus.out_r};
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_z     = 1'b0;
        bus.in_c     = 1'b0;
        bus.in_s     = 1'b0;
    endtask

    // Present one entry {s,c,z,r}; transfer occurs at the next rising edge
    task automatic drive_push(input logic [6:0] e);
        bus.in_valid = 1'b1;
        bus.in_r     = e[3:0];
        bus.in_z     = e[4];
        bus.in_c     = e[5];
        bus.in_s     = e[6];
    endtask

    logic [6:0] fill_v [5];
    logic [6:0] conc_v [6];

    initial begin
        errors = 0;
        checks = 0;
        // entries are {s,c,z,r}
        fill_v[0] = {1'b1, 1'b0, 1'b0, 4'b1000};
        fill_v[1] = {1'b0, 1'b0, 1'b1, 4'b0000};
        fill_v[2] = {1'b0, 1'b0, 1'b1, 4'b0000};
        fill_v[3] = {1'b0, 1'b0, 1'b0, 4'b0010};
        fill_v[4] = {1'b0, 1'b0, 1'b0, 4'b0110};
        conc_v[0] = {1'b1, 1'b0, 1'b0, 4'b1010};
        conc_v[1] = {1'b1, 1'b1, 1'b0, 4'b1011};
        conc_v[2] = {1'b0, 1'b0, 1'b1, 4'b0000};
        conc_v[3] = {1'b1, 1'b0, 1'b0, 4'b1101};
        conc_v[4] = {1'b0, 1'b1, 1'b0, 4'b0111};
        conc_v[5] = {1'b1, 1'b0, 1'b0, 4'b1111};

        rst_n          = 1'b0;
        bus.out_ready  = 1'b0;
        bus.sticky_clr = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(bus.count), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out", head_entry(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single push, visible one cycle later, no fall-through
        drive_push({1'b1, 1'b1, 1'b0, 4'b1000});
        #1;
        check("no_fallthru", 32'(bus.out_valid), 0);
        @(negedge clk);
        drive_idle();
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_entry", head_entry(), 32'({1'b1, 1'b1, 1'b0, 4'b1000}));
        check("single_count", 32'(bus.count), 1);
        check("single_sticky_c", 32'(bus.sticky_c), 1);
        check("single_sticky_s", 32'(bus.sticky_s), 1);

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("pop_count", 32'(bus.count), 0);
        check("pop_out_valid", 32'(bus.out_valid), 0);
        check("pop_out_zero", head_entry(), 0);

        // Sticky clear alone
        bus.sticky_clr = 1'b1;
        @(negedge clk);
        bus.sticky_clr = 1'b0;
        check("clr_sticky_c", 32'(bus.sticky_c), 0);
        check("clr_sticky_s", 32'(bus.sticky_s), 0);
        check("clr_drop_err", 32'(bus.drop_err), 0);

        // Fill to full, fifth push is dropped
        for (int i = 0; i < 5; i++) begin
            drive_push(fill_v[i]);
            if (i == 4) begin
                check("full_in_ready", 32'(bus.in_ready), 0);
            end else begin
                exp_q.push_back(fill_v[i]);
            end
            @(negedge clk);
        end
        drive_idle();
        check("full_count", 32'(bus.count), 4);
        check("full_in_ready_after", 32'(bus.in_ready), 0);
        check("full_drop_err", 32'(bus.drop_err), 1);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_e = exp_q.pop_front();
            check($sformatf("drain_%0d", i), head_entry(), 32'(exp_e));
            @(negedge clk);
            if (i == 0) begin
                check("drain_in_ready", 32'(bus.in_ready), 1);
            end
        end
        bus.out_ready = 1'b0;
        check("drain_count", 32'(bus.count), 0);

        // Sticky clear loses to a same-cycle set
        drive_push({1'b0, 1'b1, 1'b0, 4'b0101});
        bus.sticky_clr = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 4'b0101});
        @(negedge clk);
        bus.sticky_clr = 1'b0;
        drive_idle();
        check("clrset_sticky_c", 32'(bus.sticky_c), 1);
        check("clrset_sticky_s", 32'(bus.sticky_s), 0);
        check("clrset_drop_err", 32'(bus.drop_err), 0);

        drive_push({1'b0, 1'b0, 1'b0, 4'b0011});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0011});
        @(negedge clk);
        drive_idle();
        check("conc_pre_count", 32'(bus.count), 2);

        // Concurrent push+pop at count 2; write pointer wraps during this loop
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_push(conc_v[i]);
            check($sformatf("conc_count_%0d", i), 32'(bus.count), 2);
            check($sformatf("conc_head_%0d", i), head_entry(), 32'(exp_q[0]));
            @(negedge clk);
            void'(exp_q.pop_front());
            exp_q.push_back(conc_v[i]);
        end
        drive_idle();
        check("conc_post_count", 32'(bus.count), 2);
        for (int i = 0; i < 2; i++) begin
            exp_e = exp_q.pop_front();
            check($sformatf("conc_drain_%0d", i), head_entry(), 32'(exp_e));
            @(negedge clk);
        end

        // Pops on an empty FIFO are ignored
        for (int i = 0; i < 3; i++) begin
            check($sformatf("empty_count_%0d", i), 32'(bus.count), 0);
            check($sformatf("empty_valid_%0d", i), 32'(bus.out_valid), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;

        drive_push({1'b1, 1'b1, 1'b0, 4'b1001});
        @(negedge clk);
        drive_push({1'b0, 1'b0, 1'b0, 4'b0100});
        @(negedge clk);
        drive_idle();
        check("post_empty_count", 32'(bus.count), 2);
        check("post_empty_head", head_entry(), 32'({1'b1, 1'b1, 1'b0, 4'b1001}));

        // Asynchronous reset mid-cycle with two entries and stickies set
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 0);
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_in_ready", 32'(bus.in_ready), 1);
        check("arst_out", head_entry(), 0);
        check("arst_stickies", 32'({bus.sticky_c, bus.sticky_s, bus.drop_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_count", 32'(bus.count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
